simon_key_sched: RTL and testbench

//  Parametrised SIMON key-expansion engine; successor of the fixed 128/128 key unit.

---
 rtl/simon_key_sched_if.sv | 32 +++
 rtl/simon_key_sched.sv | 163 ++++++++++++++++
 tb/tb_simon_key_sched.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_key_sched_if.sv
// Key-load and round-key stream bundle for simon_key_sched.
// Latency: none, wires only.
// Backpressure: rk_valid/rk_ready. The consumer holds rk_ready low to stall the stream.
//  start/key_in     loader -> engine   begin a schedule with this master key
//  busy/done        engine -> loader   schedule in progress / one-cycle completion pulse
//  rk_valid/rk_out/rk_idx  engine -> consumer   round key stream
//  rk_ready         consumer -> engine
interface simon_key_sched_if #(
    parameter int N = 64,
    parameter int M = 2
);
    logic             start;
    logic [M*N-1:0]   key_in;
    logic             busy;
    logic             rk_valid;
    logic             rk_ready;
    logic [N-1:0]     rk_out;
    logic [7:0]       rk_idx;
    logic             done;

    // master: key loader / round datapath side
    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_idx, done
    );

    // slave: the key-expansion engine
    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_idx, done
    );
endinterface

// File: rtl/simon_key_sched.sv
// Parametrised SIMON key expansion; streams round keys k0..k(ROUNDS-1) in order.
// Latency: k0 is valid the cycle after start is accepted; then one key per accepted transfer.
// Backpressure: rk_ready low holds rk_out/rk_idx and all schedule state; no key is dropped.
//  Ports: clk, rst (synchronous, active-low), bus (simon_key_sched_if.slave).
//  Optional macro SIMON_KEY_STORE_EN adds rd_addr/rd_data, a read port onto a
//  ROUNDS x N store of every key transferred, with 1-cycle registered reads.
module simon_key_sched #(
    parameter int          N      = 64,
    parameter int          M      = 2,
    parameter int          ROUNDS = 68,
    parameter logic [61:0] Z_INIT = 62'h3369f885192c0ef5
) (
    input  logic             clk,
    input  logic             rst,
    simon_key_sched_if.slave bus
`ifdef SIMON_KEY_STORE_EN
    ,
    input  logic [7:0]       rd_addr,
    output logic [N-1:0]     rd_data
`endif
);

    // Reject configurations outside the SIMON family at elaboration
    if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_n
        $error("simon_key_sched: unsupported word size N");
    end
    if (!(M == 2 || M == 3 || M == 4)) begin : g_bad_m
        $error("simon_key_sched: unsupported key word count M");
    end
    if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
        $error("simon_key_sched: ROUNDS must be 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [N-1:0] C_CONST  = {N{1'b1}} ^ N'(3);
    localparam logic [7:0]   LAST_IDX = 8'(ROUNDS - 1);

    state_t       state_q, state_d;
    logic [N-1:0] w_q [M];
    logic [N-1:0] w_d [M];
    logic [61:0]  z_q, z_d;
    logic [7:0]   idx_q, idx_d;

    logic         xfer;
    logic [N-1:0] t_word;
    logic [N-1:0] new_word;

    // A key moves only while a schedule is running and the consumer takes it
    assign xfer = (state_q == S_RUN) && bus.rk_ready;

    // Next key word from the sliding window; W[0] is the oldest key word
    always_comb begin
        t_word = {w_q[M-1][2:0], w_q[M-1][N-1:3]};
        if (M == 4) begin
            t_word = t_word ^ w_q[1];
        end
        new_word = C_CONST ^ {{(N-1){1'b0}}, z_q[0]} ^ w_q[0]
                 ^ t_word ^ {t_word[0], t_word[N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        z_d     = z_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    for (int i = 0; i < M; i++) begin
                        w_d[i] = bus.key_in[i*N +: N];
                    end
                    z_d   = Z_INIT;
                    idx_d = 8'd0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    for (int i = 0; i < M - 1; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    w_d[M-1] = new_word;
                    z_d      = {z_q[0], z_q[61:1]};
                    if (idx_q == LAST_IDX) begin
                        // index stays on the last key so it never exceeds ROUNDS-1
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_FIN: begin
                // start is deliberately ignored here; the next IDLE cycle may accept it
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < M; i++) begin
                w_q[i] <= '0;
            end
            z_q   <= Z_INIT;
            idx_q <= 8'd0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < M; i++) begin
                w_q[i] <= w_d[i];
            end
            z_q   <= z_d;
            idx_q <= idx_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.rk_valid = (state_q == S_RUN);
    assign bus.done     = (state_q == S_FIN);
    assign bus.rk_out   = w_q[0];
    assign bus.rk_idx   = idx_q;

`ifdef SIMON_KEY_STORE_EN
    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    logic [N-1:0] key_mem [ROUNDS];
    logic [N-1:0] rd_data_q, rd_data_d;

    // Key store has no reset: contents survive reset and done, and are
    // overwritten by the next schedule
    always_ff @(posedge clk) begin
        if (rst && xfer) begin
            key_mem[idx_q[IW-1:0]] <= w_q[0];
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < 8'(ROUNDS)) begin
            rd_data_d = key_mem[rd_addr[IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_simon_key_sched.sv
// Scoreboard bench for simon_key_sched: 128/128 and 32/64 configurations.
// Latency: checks k0 valid one cycle after start, done one cycle after the last key.
// Backpressure: random rk_ready phases check that stalled outputs hold.
module tb_simon_key_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [61:0] Z2 = 62'h3369f885192c0ef5;
    // z0 with bit 0 = first element of the sequence (consumed LSB-first)
    localparam logic [61:0] Z0 =
        62'b01_10011_10000_11010_10010_00101_11110_11001_11000_01101_01001_00010_11111;

    simon_key_sched_if #(.N(64), .M(2)) b1 ();
    simon_key_sched_if #(.N(16), .M(4)) b2 ();

`ifdef SIMON_KEY_STORE_EN
    logic [7:0]  rd_addr1, rd_addr2;
    logic [63:0] rd_data1;
    logic [15:0] rd_data2;
`endif

    simon_key_sched #(.N(64), .M(2), .ROUNDS(68), .Z_INIT(Z2)) u1 (
        .clk     (clk),
        .rst     (rst),
        .bus     (b1)
`ifdef SIMON_KEY_STORE_EN
        ,
        .rd_addr (rd_addr1),
        .rd_data (rd_data1)
`endif
    );

    simon_key_sched #(.N(16), .M(4), .ROUNDS(32), .Z_INIT(Z0)) u2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (b2)
`ifdef SIMON_KEY_STORE_EN
        ,
        .rd_addr (rd_addr2),
        .rd_data (rd_data2)
`endif
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [63:0] key;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          pend_done [2];
    bit          hold_v    [2];
    logic [63:0] hold_o    [2];
    logic [7:0]  hold_i    [2];
    logic [63:0] last_key  [2];
    int          rounds_of [2] = '{68, 32};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] rorn(input logic [63:0] x, input int s, input int n);
        logic [63:0] mask;
        mask = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
        return ((x >> s) | (x << (n - s))) & mask;
    endfunction

    // Reference key expansion straight from the SIMON recurrence
    task automatic push_sched(input int ch, input int n, input int m, input int rounds,
                              input logic [61:0] zi, input logic [255:0] key);
        logic [63:0] mask, t, nw;
        logic [63:0] k[$];
        exp_t        e;
        mask = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) k.push_back(64'(key >> (i * n)) & mask);
        for (int i = 0; i < rounds; i++) begin
            e.idx = 8'(i);
            e.key = k[i];
            if (ch == 0) sb0.push_back(e);
            else         sb1.push_back(e);
            last_key[ch] = k[i];
            t = rorn(k[i+m-1], 3, n);
            if (m == 4) t = t ^ k[i+1];
            nw = (mask ^ 64'd3) ^ {63'd0, zi[i % 62]} ^ k[i] ^ t ^ rorn(t, 1, n);
            k.push_back(nw & mask);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall hold and done timing
    task automatic mon(input int ch, input logic vld, input logic rdy, input logic dn,
                       input logic bsy, input logic [63:0] o, input logic [7:0] ix);
        exp_t e;
        int   sz;
        if (!rst) begin
            pend_done[ch] = 1'b0;
            hold_v[ch]    = 1'b0;
            return;
        end
        if (pend_done[ch]) begin
            chk("done_pulse", {63'd0, dn}, 64'd1);
            chk("busy_at_done", {63'd0, bsy}, 64'd0);
            chk("valid_after_last", {63'd0, vld}, 64'd0);
            pend_done[ch] = 1'b0;
        end else if (dn) begin
            chk("spurious_done", {63'd0, dn}, 64'd0);
        end
        if (vld && hold_v[ch]) begin
            chk("stall_out", o, hold_o[ch]);
            chk("stall_idx", {56'd0, ix}, {56'd0, hold_i[ch]});
        end
        if (vld && rdy) begin
            sz = (ch == 0) ? sb0.size() : sb1.size();
            if (sz == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("rk_idx", {56'd0, ix}, {56'd0, e.idx});
                chk("rk_out", o, e.key);
                if (int'(e.idx) == rounds_of[ch] - 1) pend_done[ch] = 1'b1;
            end
            hold_v[ch] = 1'b0;
        end else if (vld) begin
            hold_v[ch] = 1'b1;
            hold_o[ch] = o;
            hold_i[ch] = ix;
        end else begin
            hold_v[ch] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, b1.rk_valid, b1.rk_ready, b1.done, b1.busy, b1.rk_out, b1.rk_idx);
        mon(1, b2.rk_valid, b2.rk_ready, b2.done, b2.busy, {48'd0, b2.rk_out}, b2.rk_idx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int ch);
        if (ch == 0) b1.start = 1'b1; else b2.start = 1'b1;
        tick();
        b1.start = 1'b0;
        b2.start = 1'b0;
        if (ch == 0) chk("latency_valid", {63'd0, b1.rk_valid}, 64'd1);
        else         chk("latency_valid", {63'd0, b2.rk_valid}, 64'd1);
    endtask

    // Runs one schedule to completion. Flags: random ready, start at idx 10,
    // start in the done cycle, reset at idx 20 (ch 0 only for the last three).
    task automatic run(input int ch, input bit rnd, input bit st10, input bit stdn, input bit rst20);
        int  cyc;
        bit  fin;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            if (rnd) b1.rk_ready = 1'($urandom_range(0, 1));
            b1.start = 1'b0;
            if (ch == 0 && st10 && b1.rk_idx == 8'd10 && b1.rk_valid) b1.start = 1'b1;
            if (ch == 0 && stdn && b1.done) b1.start = 1'b1;
            if (ch == 0 && rst20 && b1.rk_idx == 8'd20) begin
                rst = 1'b0;
                sb0.delete();
                tick();
                chk("abort_busy", {63'd0, b1.busy}, 64'd0);
                chk("abort_valid", {63'd0, b1.rk_valid}, 64'd0);
                chk("abort_idx", {56'd0, b1.rk_idx}, 64'd0);
                chk("abort_out", b1.rk_out, 64'd0);
                rst = 1'b1;
                return;
            end
            tick();
            cyc++;
            if (ch == 0) fin = !b1.busy && !b1.done && sb0.size() == 0;
            else         fin = !b2.busy && !b2.done && sb1.size() == 0;
            if (cyc > 2000) begin
                chk("timeout", 64'd1, 64'd0);
                fin = 1'b1;
            end
        end
        b1.start     = 1'b0;
        b1.rk_ready  = 1'b1;
    endtask

    localparam logic [255:0] KEY1 = 256'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [255:0] KEY2 = 256'h1918_1110_0908_0100;

    initial begin
        rst         = 1'b0;
        b1.start    = 1'b0;
        b1.key_in   = KEY1[127:0];
        b1.rk_ready = 1'b1;
        b2.start    = 1'b0;
        b2.key_in   = KEY2[63:0];
        b2.rk_ready = 1'b1;
`ifdef SIMON_KEY_STORE_EN
        rd_addr1 = 8'd0;
        rd_addr2 = 8'd0;
`endif
        repeat (3) tick();
        chk("rst_busy", {63'd0, b1.busy}, 64'd0);
        chk("rst_valid", {63'd0, b1.rk_valid}, 64'd0);
        chk("rst_done", {63'd0, b1.done}, 64'd0);
        chk("rst_out", b1.rk_out, 64'd0);
        chk("rst_idx", {56'd0, b1.rk_idx}, 64'd0);
        chk("rst_valid2", {63'd0, b2.rk_valid}, 64'd0);
`ifdef SIMON_KEY_STORE_EN
        chk("rst_rd_data", rd_data1, 64'd0);
`endif
        rst = 1'b1;
        tick();

        // 128/128 with continuous ready
        push_sched(0, 64, 2, 68, Z2, KEY1);
        do_start(0);
        chk("k0_first", b1.rk_out, 64'h0706050403020100);
        run(0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SIMON_KEY_STORE_EN
        rd_addr1 = 8'd0;
        tick();
        chk("rd_k0", rd_data1, 64'h0706050403020100);
        rd_addr1 = 8'd67;
        tick();
        chk("rd_k67", rd_data1, last_key[0]);
        rd_addr1 = 8'd68;
        tick();
        chk("rd_oob", rd_data1, 64'd0);
`endif

        // 32/64 with z0
        push_sched(1, 16, 4, 32, Z0, KEY2);
        do_start(1);
        chk("k0_32_64", {48'd0, b2.rk_out}, 64'h0100);
        run(1, 1'b0, 1'b0, 1'b0, 1'b0);

        // random backpressure
        push_sched(0, 64, 2, 68, Z2, KEY1);
        do_start(0);
        run(0, 1'b1, 1'b0, 1'b0, 1'b0);

        // start pulses during RUN and in the done cycle are ignored
        push_sched(0, 64, 2, 68, Z2, KEY1);
        do_start(0);
        run(0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("no_restart_busy", {63'd0, b1.busy}, 64'd0);
        chk("no_restart_valid", {63'd0, b1.rk_valid}, 64'd0);

        // abort at idx 20, then a clean rerun
        push_sched(0, 64, 2, 68, Z2, KEY1);
        do_start(0);
        run(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        push_sched(0, 64, 2, 68, Z2, KEY1);
        do_start(0);
        chk("rerun_k0", b1.rk_out, 64'h0706050403020100);
        run(0, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        chk("sb0_drained", 64'(sb0.size()), 64'd0);
        chk("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
